// File: rtl/and_gate_triplex_if.sv
// -----------------------------------------------------------------------------
// and_gate_triplex_if
// Groups the operand, control and result signals of and_gate_triplex.
//   master : drives a, b, in_valid, inj_str, clr; observes every result
//   slave  : the AND block itself (consumes operands, produces results)
// Signals:
//   a, b        operands (WIDTH)
//   in_valid    qualifies a/b for the registered path and error accounting
//   inj_str     fault-injection mask XORed onto the structural result
//   clr         synchronous clear of sticky error flag and counter
//   y_df/y_beh/y_str/y_vote  combinational results (WIDTH)
//   mismatch    combinational disagreement between the three paths
//   y_q, out_valid           registered vote and valid
//   err_sticky, err_count    error accounting (err_count is CNT_W wide)
// -----------------------------------------------------------------------------
interface and_gate_triplex_if #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_valid;
   logic [WIDTH-1:0] inj_str;
   logic             clr;
   logic [WIDTH-1:0] y_df;
   logic [WIDTH-1:0] y_beh;
   logic [WIDTH-1:0] y_str;
   logic [WIDTH-1:0] y_vote;
   logic             mismatch;
   logic [WIDTH-1:0] y_q;
   logic             out_valid;
   logic             err_sticky;
   logic [CNT_W-1:0] err_count;

   modport master (
      output a, b, in_valid, inj_str, clr,
      input  y_df, y_beh, y_str, y_vote, mismatch,
             y_q, out_valid, err_sticky, err_count
   );

   modport slave (
      input  a, b, in_valid, inj_str, clr,
      output y_df, y_beh, y_str, y_vote, mismatch,
             y_q, out_valid, err_sticky, err_count
   );
endinterface

// File: rtl/and_gate_triplex.sv
// -----------------------------------------------------------------------------
// and_gate_triplex
// Bitwise AND computed three independent ways (dataflow, behavioural, gate
// primitives), majority-voted, registered, and cross-checked. Disagreement on
// a valid cycle sets a sticky flag and bumps a saturating counter.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset of all registered state
//   bus    and_gate_triplex_if.slave carrying operands, controls and results
// Parameters:
//   WIDTH  operand/result width (1..64), must match the interface instance
//   CNT_W  error counter width (1..32), must match the interface instance
// -----------------------------------------------------------------------------
module and_gate_triplex #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   and_gate_triplex_if.slave  bus
);

   logic [WIDTH-1:0] w_df;
   logic [WIDTH-1:0] w_beh;
   logic [WIDTH-1:0] w_str_raw;
   logic [WIDTH-1:0] w_str;
   logic [WIDTH-1:0] w_vote;
   logic             w_mismatch;
   logic             w_event;
   logic [CNT_W-1:0] w_cnt_inc;

   logic [WIDTH-1:0] r_y_q;
   logic             r_out_valid;
   logic             r_err_sticky;
   logic [CNT_W-1:0] r_err_count;

   // Dataflow path
   assign w_df = bus.a & bus.b;

   // Behavioural path
   always_comb begin
      w_beh = '0;
      w_beh = bus.a & bus.b;
   end

   // Structural path: one gate primitive per bit, then the injection mask
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_str
         and u_and_bit (w_str_raw[gi], bus.a[gi], bus.b[gi]);
      end
   endgenerate

   assign w_str = w_str_raw ^ bus.inj_str;

   // Bitwise 2-of-3 majority: any single faulty path is outvoted
   assign w_vote     = (w_df & w_beh) | (w_df & w_str) | (w_beh & w_str);
   assign w_mismatch = |((w_df ^ w_beh) | (w_df ^ w_str));
   assign w_event    = bus.in_valid & w_mismatch;

   // Saturating increment: hold at all-ones rather than wrapping to zero
   assign w_cnt_inc = (r_err_count == {CNT_W{1'b1}}) ? r_err_count
                                                      : r_err_count + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y_q        <= '0;
         r_out_valid  <= 1'b0;
         r_err_sticky <= 1'b0;
         r_err_count  <= '0;
      end else begin
         r_out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_y_q <= w_vote;
         end
         // A fresh event outranks a coincident clear so no fault is lost
         if (w_event) begin
            r_err_sticky <= 1'b1;
         end else if (bus.clr) begin
            r_err_sticky <= 1'b0;
         end
         if (bus.clr) begin
            r_err_count <= w_event ? CNT_W'(1) : '0;
         end else if (w_event) begin
            r_err_count <= w_cnt_inc;
         end
      end
   end

   assign bus.y_df       = w_df;
   assign bus.y_beh      = w_beh;
   assign bus.y_str      = w_str;
   assign bus.y_vote     = w_vote;
   assign bus.mismatch   = w_mismatch;
   assign bus.y_q        = r_y_q;
   assign bus.out_valid  = r_out_valid;
   assign bus.err_sticky = r_err_sticky;
   assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_and_gate_triplex.sv
// -----------------------------------------------------------------------------
// tb_and_gate_triplex
// Two instances: WIDTH=1 for the truth table, WIDTH=8/CNT_W=2 for the
// registered path, fault injection, saturation, clear and async reset.
// Registered results go through a scoreboard queue popped by a monitor on the
// falling edge whenever out_valid is high; combinational and idle-cycle state
// is checked directly against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_and_gate_triplex;

   logic clk;
   logic rst_n;

   and_gate_triplex_if #(.WIDTH(1), .CNT_W(8)) bus1 ();
   and_gate_triplex_if #(.WIDTH(8), .CNT_W(2)) bus8 ();

   and_gate_triplex #(.WIDTH(1), .CNT_W(8)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   and_gate_triplex #(.WIDTH(8), .CNT_W(2)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   typedef struct {
      logic [7:0] y;
      logic       s;
      logic [1:0] c;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] inj,
                         input logic v, input logic c);
      bus8.a        = a;
      bus8.b        = b;
      bus8.inj_str  = inj;
      bus8.in_valid = v;
      bus8.clr      = c;
   endtask

   task automatic push(input logic [7:0] y, input logic s, input logic [1:0] c);
      exp_t e;
      e.y = y;
      e.s = s;
      e.c = c;
      q.push_back(e);
   endtask

   // Monitor: one line per registered transaction
   always @(negedge clk) begin
      if (rst_n && bus8.out_valid) begin
         if (q.size() == 0) begin
            chk("spurious_out_valid", 64'(bus8.out_valid), 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            $display("txn y_q=%02h sticky=%0d count=%0d (exp %02h %0d %0d)",
                     bus8.y_q, bus8.err_sticky, bus8.err_count, e.y, e.s, e.c);
            chk("txn_y_q", 64'(bus8.y_q), 64'(e.y));
            chk("txn_err_sticky", 64'(bus8.err_sticky), 64'(e.s));
            chk("txn_err_count", 64'(bus8.err_count), 64'(e.c));
         end
      end
   end

   logic [1:0] tt_ab [4];
   logic       tt_y  [4];

   initial begin
      rst_n = 1'b0;
      bus1.a = '0; bus1.b = '0; bus1.in_valid = 1'b0; bus1.inj_str = '0; bus1.clr = 1'b0;
      drive8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

      // Reset state
      #8;
      chk("rst_y_q", 64'(bus8.y_q), 64'd0);
      chk("rst_out_valid", 64'(bus8.out_valid), 64'd0);
      chk("rst_err_sticky", 64'(bus8.err_sticky), 64'd0);
      chk("rst_err_count", 64'(bus8.err_count), 64'd0);
      chk("rst_w1_err_count", 64'(bus1.err_count), 64'd0);

      // WIDTH=1 truth table, 5 ns per vector
      tt_ab[0] = 2'b00; tt_y[0] = 1'b0;
      tt_ab[1] = 2'b01; tt_y[1] = 1'b0;
      tt_ab[2] = 2'b10; tt_y[2] = 1'b0;
      tt_ab[3] = 2'b11; tt_y[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus1.a = tt_ab[i][1];
         bus1.b = tt_ab[i][0];
         #1;
         chk("tt_y_df", 64'(bus1.y_df), 64'(tt_y[i]));
         chk("tt_y_beh", 64'(bus1.y_beh), 64'(tt_y[i]));
         chk("tt_y_str", 64'(bus1.y_str), 64'(tt_y[i]));
         chk("tt_y_vote", 64'(bus1.y_vote), 64'(tt_y[i]));
         chk("tt_mismatch", 64'(bus1.mismatch), 64'd0);
         #4;
      end
      #1;
      rst_n = 1'b1;
      tick();

      // Single clean transaction
      drive8(8'hA5, 8'h0F, 8'h00, 1'b1, 1'b0);
      #1;
      chk("clean_y_vote", 64'(bus8.y_vote), 64'h05);
      chk("clean_mismatch", 64'(bus8.mismatch), 64'd0);
      push(8'h05, 1'b0, 2'd0);
      tick();
      drive8(8'hA5, 8'h0F, 8'h00, 1'b0, 1'b0);
      tick();
      chk("idle_out_valid", 64'(bus8.out_valid), 64'd0);
      chk("idle_y_q_hold", 64'(bus8.y_q), 64'h05);

      // Injected single-path fault
      drive8(8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0);
      #1;
      chk("inj_y_str", 64'(bus8.y_str), 64'hFE);
      chk("inj_y_vote", 64'(bus8.y_vote), 64'hFF);
      chk("inj_mismatch", 64'(bus8.mismatch), 64'd1);
      push(8'hFF, 1'b1, 2'd1);
      tick();
      drive8(8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0);
      tick();
      chk("invalid_fault_count", 64'(bus8.err_count), 64'd1);
      chk("invalid_fault_sticky", 64'(bus8.err_sticky), 64'd1);

      // Clear with no event
      drive8(8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1);
      tick();
      chk("clr_count", 64'(bus8.err_count), 64'd0);
      chk("clr_sticky", 64'(bus8.err_sticky), 64'd0);

      // Saturation with CNT_W=2
      drive8(8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0);
      push(8'hFF, 1'b1, 2'd1);
      push(8'hFF, 1'b1, 2'd2);
      push(8'hFF, 1'b1, 2'd3);
      push(8'hFF, 1'b1, 2'd3);
      push(8'hFF, 1'b1, 2'd3);
      push(8'hFF, 1'b1, 2'd3);
      repeat (6) tick();

      // Clear coincident with an event: event wins
      drive8(8'hFF, 8'hFF, 8'h01, 1'b1, 1'b1);
      push(8'hFF, 1'b1, 2'd1);
      tick();

      // Build up y_q = 0x05, err_count = 2
      drive8(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      tick();
      drive8(8'hA5, 8'h0F, 8'h01, 1'b1, 1'b0);
      #1;
      chk("pre_rst_y_vote", 64'(bus8.y_vote), 64'h05);
      push(8'h05, 1'b1, 2'd1);
      tick();
      push(8'h05, 1'b1, 2'd2);
      tick();
      drive8(8'hA5, 8'h0F, 8'h00, 1'b0, 1'b0);
      tick();
      chk("pre_rst_y_q", 64'(bus8.y_q), 64'h05);
      chk("pre_rst_count", 64'(bus8.err_count), 64'd2);

      // Asynchronous reset pulse between edges
      #1;
      rst_n = 1'b0;
      bus8.a = 8'h3C;
      bus8.b = 8'hF0;
      #1;
      chk("arst_y_q", 64'(bus8.y_q), 64'd0);
      chk("arst_out_valid", 64'(bus8.out_valid), 64'd0);
      chk("arst_sticky", 64'(bus8.err_sticky), 64'd0);
      chk("arst_count", 64'(bus8.err_count), 64'd0);
      chk("arst_y_df", 64'(bus8.y_df), 64'h30);
      chk("arst_y_vote", 64'(bus8.y_vote), 64'h30);
      chk("arst_mismatch", 64'(bus8.mismatch), 64'd0);
      #1;
      rst_n = 1'b1;
      tick();

      // Resumes after reset
      drive8(8'h3C, 8'hF0, 8'h00, 1'b1, 1'b0);
      push(8'h30, 1'b0, 2'd0);
      tick();
      drive8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         @(posedge clk);
      end
      chk("scoreboard_drained", 64'(q.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/and_gate_triplex.md
Name: and_gate_triplex

Overview:
- Bitwise two-input AND block built three ways in parallel: dataflow, behavioural and gate-primitive structural.
- The three results are exposed combinationally, majority-voted, and registered.
- The block also cross-checks the three paths and reports disagreement through a sticky flag and a saturating error counter.
- It serves as the team's reference/self-checking AND primitive in the basic-gates library.

Parameters:
WIDTH, 1, bit width of operands and results (legal 1..64)
CNT_W, 8, width of mismatch error counter (legal 1..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
a  input  WIDTH  operand A
b  input  WIDTH  operand B
in_valid  input  1  qualifies a/b for registered path and error accounting
inj_str  input  WIDTH  fault-injection mask, XORed onto structural result (tie 0 in normal use)
clr  input  1  synchronous clear of sticky error and counter
y_df  output  WIDTH  dataflow result, combinational
y_beh  output  WIDTH  behavioural result, combinational
y_str  output  WIDTH  structural result (after injection), combinational
y_vote  output  WIDTH  bitwise 2-of-3 majority of y_df/y_beh/y_str, combinational
mismatch  output  1  combinational: any bit where the three paths disagree
y_q  output  WIDTH  registered y_vote
out_valid  output  1  registered in_valid
err_sticky  output  1  set on any valid mismatch, held until clr
err_count  output  CNT_W  saturating count of valid mismatch cycles

Behaviour:
- Path implementations:
  - y_df: continuous assignment a & b.
  - y_beh: procedural combinational block computing a & b.
  - y_str: per-bit AND gate primitive instances (generate loop), then XOR with inj_str.
- With inj_str = 0, all three paths equal a & b for every input value, including WIDTH=1 truth table: 00->0, 01->0, 10->0, 11->1.
- Combinational outputs have zero-cycle latency and are unaffected by clk, rst_n, in_valid and clr.
- Vote: y_vote[i] = (df&beh) | (df&str) | (beh&str) per bit. A single faulty path never changes y_vote.
- Mismatch: mismatch = |((y_df ^ y_beh) | (y_df ^ y_str)).
- Registered path (rising clk, after reset release):
  - out_valid <= in_valid every cycle.
  - y_q <= y_vote only when in_valid = 1; otherwise y_q holds.
  - Latency is 1 cycle from in_valid/a/b to out_valid/y_q.
- Error accounting (per rising clk):
  - Event = in_valid & mismatch. Mismatches with in_valid = 0 are ignored.
  - err_sticky <= event ? 1 : (clr ? 0 : err_sticky).
  - err_count <= clr ? (event ? 1 : 0) : (event ? sat_inc(err_count) : err_count).
  - sat_inc saturates at 2^CNT_W-1 and never wraps.
  - Simultaneous clr and event: event wins. err_sticky = 1, err_count = 1.
- Reset:
  - rst_n low asynchronously forces y_q = 0, out_valid = 0, err_sticky = 0, err_count = 0, independent of clk.
  - Registered state resumes on the first rising clk after rst_n deasserts.
  - Reset asserted mid-stream discards any in-flight y_q/out_valid.
- X/Z on inputs: no special handling is required. Combinational outputs follow normal 4-state operator semantics.

Test Plan:
- WIDTH=1, inj_str=0, {a,b} = 00,01,10,11 held 5 ns each -> y_df = y_beh = y_str = y_vote = 0,0,0,1; mismatch = 0 throughout.
- WIDTH=8, a=0xA5, b=0x0F, in_valid=1 for one cycle -> y_vote = 0x05 immediately; y_q = 0x05 and out_valid = 1 one clk later; out_valid = 0 the following cycle while y_q holds 0x05.
- WIDTH=8, a=b=0xFF, inj_str=0x01, in_valid=1 -> y_str = 0xFE, y_vote = 0xFF, mismatch = 1; next clk err_sticky = 1, err_count = 1. Same fault with in_valid = 0 -> counter unchanged.
- CNT_W=2, continuous injected mismatch with in_valid=1 for 6 cycles -> err_count 1,2,3,3,3,3. clr with no event -> count 0, sticky 0. clr coincident with event -> count 1, sticky 1.
- Pulse rst_n low between clock edges while y_q = 0x05 and err_count = 2 -> y_q, out_valid, err_sticky and err_count go to 0 immediately with no clk edge; combinational outputs keep tracking a & b.
